router_out_arbiter: RTL and testbench

//  Per-output-port switch allocator for the 5-port mesh router. It arbitrates among
//  the input ports whose head-of-queue flit targets this output, with round-robin

---
 rtl/router_out_arbiter_if.sv | 29 ++
 rtl/router_out_arbiter.sv | 161 ++++++++++++++++
 tb/tb_router_out_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between the input ports, one output arbiter and the downstream link.
//   req_in   : per-input request, head-of-queue flit targets this output
//   flit_in  : packed head-of-queue flits, input i at [i*FLIT_W +: FLIT_W]
//   pop_out  : one-hot, flit of input i consumed this cycle
//   out_flit : registered flit toward the downstream router
//   out_req  : out_flit valid
//   in_ack   : downstream accepts out_flit this cycle
// The master modport is the upstream/downstream side; slave is the arbiter.
interface router_out_arbiter_if #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned FLIT_W  = 34
);
  logic [N_PORTS-1:0]        req_in;
  logic [N_PORTS*FLIT_W-1:0] flit_in;
  logic [N_PORTS-1:0]        pop_out;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_req;
  logic                      in_ack;

  modport master (
    output req_in, flit_in, in_ack,
    input  pop_out, out_flit, out_req
  );

  modport slave (
    input  req_in, flit_in, in_ack,
    output pop_out, out_flit, out_req
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Per-output switch allocator: round-robin among head flits, wormhole lock on the winner
// until its tail, one-entry registered output slot with out_req/in_ack handshake.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : request/flit/pop and output handshake bundle (slave side)
//   grant   : one-hot wormhole owner, zero while idle
//   pkt_cnt : packets forwarded (tail or head+tail popped), wraps
//   err     : sticky protocol-error flag
// Flit type in the top two bits: 10 head, 00 body, 01 tail, 11 head+tail.
module router_out_arbiter #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned FLIT_W  = 34,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  router_out_arbiter_if.slave bus,
  output logic [N_PORTS-1:0]  grant,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic                err
);

  localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_req_q, out_req_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;

  logic [FLIT_W-1:0]  flit_arr [N_PORTS];
  logic [N_PORTS-1:0] head_req;  // requesting with head or head+tail
  logic [N_PORTS-1:0] mid_req;   // requesting with body or tail
  logic               slot_free;
  logic               rr_found;
  logic [IdxW-1:0]    rr_win;
  int unsigned        srch_idx;
  logic [IdxW-1:0]    srch_idx_n;
  logic               pop_vld;
  logic [IdxW-1:0]    pop_idx;
  logic [N_PORTS-1:0] pop_out;

  // Head types are exactly those with the type MSB set.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign flit_arr[i] = bus.flit_in[i*FLIT_W +: FLIT_W];
    assign head_req[i] = bus.req_in[i] & flit_arr[i][FLIT_W-1];
    assign mid_req[i]  = bus.req_in[i] & ~flit_arr[i][FLIT_W-1];
  end

  // Slot may be refilled in the same cycle it drains.
  assign slot_free = ~out_req_q | bus.in_ack;

  // Round-robin search starting just after the last packet's winner.
  always_comb begin
    rr_found   = 1'b0;
    rr_win     = rr_ptr_q;
    srch_idx   = 0;
    srch_idx_n = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      srch_idx   = (32'(rr_ptr_q) + k) % N_PORTS;
      srch_idx_n = IdxW'(srch_idx);
      if (!rr_found && head_req[srch_idx_n]) begin
        rr_found = 1'b1;
        rr_win   = srch_idx_n;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= IdxW'(N_PORTS - 1);
      out_flit_q <= '0;
      out_req_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      out_flit_q <= out_flit_d;
      out_req_q  <= out_req_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state and pop decision.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    out_flit_d = out_flit_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q;
    pop_vld    = 1'b0;
    pop_idx    = owner_q;
    unique case (state_q)
      StIdle: begin
        if (|mid_req) err_d = 1'b1;
        if (rr_found && slot_free) begin
          pop_vld    = 1'b1;
          pop_idx    = rr_win;
          out_flit_d = flit_arr[rr_win];
          if (flit_arr[rr_win][FLIT_W-2]) begin
            // Single-flit packet: no lock, packet ends immediately.
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            rr_ptr_d  = rr_win;
          end else begin
            state_d = StLocked;
            owner_d = rr_win;
          end
        end
      end
      StLocked: begin
        if (bus.req_in[owner_q] && slot_free) begin
          pop_vld    = 1'b1;
          pop_idx    = owner_q;
          out_flit_d = flit_arr[owner_q];
          case (flit_arr[owner_q][FLIT_W-1 -: 2])
            2'b01: begin
              state_d   = StIdle;
              rr_ptr_d  = owner_q;
              pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
            2'b00: ;
            default: begin
              // Stray head inside a packet keeps the worm intact downstream.
              err_d                        = 1'b1;
              out_flit_d[FLIT_W-1 -: 2]    = 2'b00;
            end
          endcase
        end
      end
    endcase
    if (pop_vld)          out_req_d = 1'b1;
    else if (bus.in_ack)  out_req_d = 1'b0;
    else                  out_req_d = out_req_q;
  end

  // Outputs.
  always_comb begin
    pop_out = '0;
    if (pop_vld) pop_out[pop_idx] = 1'b1;
    grant = '0;
    if (state_q == StLocked) grant[owner_q] = 1'b1;
  end

  assign bus.pop_out  = pop_out;
  assign bus.out_flit = out_flit_q;
  assign bus.out_req  = out_req_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: per-input flit sources, a packet-level reference model,
// and a scoreboard monitor that checks every flit accepted downstream.
module tb_router_out_arbiter;
  localparam int N         = 5;
  localparam int FW        = 34;
  localparam int CW        = 16;
  localparam int SRC_DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  grant;
  logic [CW-1:0] pkt_cnt;
  logic          err;

  router_out_arbiter_if #(.N_PORTS(N), .FLIT_W(FW)) bus_if ();

  router_out_arbiter #(.N_PORTS(N), .FLIT_W(FW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .grant   (grant),
    .pkt_cnt (pkt_cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_f;

  logic [FW-1:0] src_mem [N][SRC_DEPTH];
  int            src_rd [N];
  int            src_wr [N];

  logic [N-1:0] req_mask;
  int           req_pct;
  int           ack_pct;
  bit           auto_refill;
  int           corrupt_pct;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_rr;
  int m_cnt;
  bit m_err;
  bit m_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_flit(input int p, input logic [1:0] t, input logic [31:0] pl);
    src_mem[p][src_wr[p] % SRC_DEPTH] = {t, pl};
    src_wr[p]++;
  endtask

  task automatic gen_packet(input int p);
    logic [1:0] bt;
    if ($urandom_range(0, 3) == 0) begin
      push_flit(p, 2'b11, $urandom());
    end else begin
      push_flit(p, 2'b10, $urandom());
      repeat ($urandom_range(0, 3)) begin
        bt = 2'b00;
        if (int'($urandom_range(0, 99)) < corrupt_pct) bt = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        push_flit(p, bt, $urandom());
      end
      push_flit(p, 2'b01, $urandom());
    end
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = N - 1;
    m_cnt    = 0;
    m_err    = 1'b0;
    m_valid  = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst              = 1'b0;
    bus_if.req_in    = '0;
    bus_if.flit_in   = '0;
    bus_if.in_ack    = 1'b0;
    model_reset();
    flush_sources();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock: drive inputs, check against the model, advance model and sources.
  task automatic step();
    logic [N-1:0]  req;
    logic [FW-1:0] fl [N];
    logic [N-1:0]  exp_pop;
    logic [N-1:0]  exp_grant;
    logic [FW-1:0] f;
    logic [1:0]    t;
    bit            ack;
    bit            slot_free;
    bit            have;
    int            pop;
    int            p;
    for (int i = 0; i < N; i++) begin
      if (auto_refill && src_rd[i] == src_wr[i]) gen_packet(i);
      have   = src_rd[i] != src_wr[i];
      fl[i]  = have ? src_mem[i][src_rd[i] % SRC_DEPTH] : {2'b00, 32'($urandom())};
      req[i] = have && req_mask[i] && (int'($urandom_range(0, 99)) < req_pct);
      bus_if.flit_in[i*FW +: FW] = fl[i];
    end
    ack           = int'($urandom_range(0, 99)) < ack_pct;
    bus_if.req_in = req;
    bus_if.in_ack = ack;
    @(negedge clk);
    exp_grant = '0;
    if (m_locked) exp_grant[m_owner] = 1'b1;
    check("grant", 64'(grant), 64'(exp_grant));
    check("out_req", 64'(bus_if.out_req), 64'(m_valid));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    check("err", 64'(err), 64'(m_err));

    slot_free = !m_valid || ack;
    pop       = -1;
    f         = '0;
    if (!m_locked) begin
      for (int i = 0; i < N; i++)
        if (req[i] && (fl[i][FW-1 -: 2] == 2'b00 || fl[i][FW-1 -: 2] == 2'b01)) m_err = 1'b1;
      if (slot_free) begin
        for (int k = 1; k <= N; k++) begin
          p = (m_rr + k) % N;
          if (pop < 0 && req[p] && (fl[p][FW-1 -: 2] == 2'b10 || fl[p][FW-1 -: 2] == 2'b11))
            pop = p;
        end
      end
      if (pop >= 0) begin
        f = fl[pop];
        if (f[FW-1 -: 2] == 2'b11) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          m_rr  = pop;
        end else begin
          m_locked = 1'b1;
          m_owner  = pop;
        end
      end
    end else if (req[m_owner] && slot_free) begin
      pop = m_owner;
      f   = fl[pop];
      t   = f[FW-1 -: 2];
      if (t == 2'b01) begin
        m_locked = 1'b0;
        m_rr     = m_owner;
        m_cnt    = (m_cnt + 1) % (1 << CW);
      end else if (t != 2'b00) begin
        m_err         = 1'b1;
        f[FW-1 -: 2]  = 2'b00;
      end
    end

    exp_pop = '0;
    if (pop >= 0) exp_pop[pop] = 1'b1;
    check("pop_out", 64'(bus_if.pop_out), 64'(exp_pop));

    if (pop >= 0) begin
      exp_q.push_back(f);
      src_rd[pop]++;
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output flit must match the oldest prediction.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus_if.out_req === 1'b1 && bus_if.in_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_flit: got %0h expected none", bus_if.out_flit);
      end else begin
        mon_f = exp_q.pop_front();
        check("out_flit", 64'(bus_if.out_flit), 64'(mon_f));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    req_mask    = '0;
    req_pct     = 100;
    ack_pct     = 100;
    auto_refill = 1'b0;
    corrupt_pct = 0;

    // Reset values
    do_reset();
    check("t1_out_req", 64'(bus_if.out_req), 64'd0);
    check("t1_grant", 64'(grant), 64'd0);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t1_err", 64'(err), 64'd0);
    check("t1_pop_out", 64'(bus_if.pop_out), 64'd0);
    step();

    // Single head+tail on input 2
    do_reset();
    push_flit(2, 2'b11, 32'h0000_00AA);
    req_mask = 5'b00100;
    step();
    check("t2_out_flit", 64'(bus_if.out_flit), 64'h3_0000_00AA);
    check("t2_out_req", 64'(bus_if.out_req), 64'd1);
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("t2_grant", 64'(grant), 64'd0);
    step();

    // Round robin over inputs 0,1,3
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_flit(0, 2'b11, 32'h100 + 32'(r));
      push_flit(1, 2'b11, 32'h200 + 32'(r));
      push_flit(3, 2'b11, 32'h300 + 32'(r));
    end
    req_mask = 5'b01011;
    repeat (6) step();
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'd6);
    repeat (2) step();

    // Wormhole on input 1 while input 0 keeps requesting
    do_reset();
    push_flit(1, 2'b10, 32'h1A);
    push_flit(1, 2'b00, 32'h1B);
    push_flit(1, 2'b00, 32'h1C);
    push_flit(1, 2'b01, 32'h1D);
    for (int r = 0; r < 6; r++) push_flit(0, 2'b11, 32'hA0 + 32'(r));
    req_mask = 5'b00011;
    repeat (12) step();

    // Downstream stall then release
    do_reset();
    for (int r = 0; r < 3; r++) push_flit(0, 2'b11, 32'h500 + 32'(r));
    req_mask = 5'b00001;
    ack_pct  = 0;
    repeat (4) step();
    check("t5_hold_req", 64'(bus_if.out_req), 64'd1);
    check("t5_hold_flit", 64'(bus_if.out_flit), 64'h3_0000_0500);
    ack_pct = 100;
    repeat (4) step();

    // Randomized traffic with well-formed packets
    do_reset();
    auto_refill = 1'b1;
    req_mask    = '1;
    req_pct     = 70;
    ack_pct     = 70;
    repeat (3000) step();

    // Reset in the middle of a locked packet, then a stray body while idle
    auto_refill = 1'b0;
    do_reset();
    req_pct  = 100;
    ack_pct  = 100;
    push_flit(2, 2'b10, 32'hC0);
    push_flit(2, 2'b00, 32'hC1);
    push_flit(2, 2'b00, 32'hC2);
    push_flit(2, 2'b01, 32'hC3);
    req_mask = 5'b00100;
    repeat (2) step();
    check("t6_locked", 64'(grant), 64'b00100);
    do_reset();
    check("t6_rst_req", 64'(bus_if.out_req), 64'd0);
    check("t6_rst_grant", 64'(grant), 64'd0);
    push_flit(4, 2'b00, 32'hBAD);
    req_mask = 5'b10000;
    step();
    check("t6_err", 64'(err), 64'd1);
    step();
    check("t6_err_sticky", 64'(err), 64'd1);

    // Randomized traffic with stray heads inside packets
    flush_sources();
    auto_refill = 1'b1;
    corrupt_pct = 15;
    req_mask    = '1;
    req_pct     = 70;
    ack_pct     = 70;
    repeat (1500) step();

    // Drain the output slot
    auto_refill = 1'b0;
    req_mask    = '0;
    ack_pct     = 100;
    repeat (3) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
